// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, shared-ALU and response signal bundle for alu_arbiter
//
// Purpose: groups the two requester handshakes, the shared ALU operand/result
// lines and the response handshake into one bundle.
// Modports:
//   slave  - arbiter side: takes requests, drives ALU operands, drives response
//   master - environment side: issues requests, returns the ALU result, consumes responses
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_out;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
//
// Purpose: grants one of two requesters, captures its operands, drives the
// shared ALU for one cycle, registers the result and holds it until taken.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of alu_arbiter_if (requests, ALU lines, response)
//   busy   out  high whenever an operation is in flight (EXEC or RESP)
// DATA_W / OP_W must match the parameters of the connected interface.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_last_grant;
    logic              r_id;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        w_gnt0         = bus.req0_valid && (!bus.req1_valid || r_last_grant);
        w_gnt1         = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
        w_next         = r_state;
        w_accept       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req0_ready = w_gnt0;
                bus.req1_ready = w_gnt1;
                w_accept       = w_gnt0 || w_gnt1;
                if (w_accept) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                // w_gnt1 doubles as the id of the accepted requester.
                r_id         <= w_gnt1;
                r_last_grant <= w_gnt1;
                r_a          <= w_gnt1 ? bus.req1_a  : bus.req0_a;
                r_b          <= w_gnt1 ? bus.req1_b  : bus.req0_b;
                r_op         <= w_gnt1 ? bus.req1_op : bus.req0_op;
            end
            if (r_state == S_EXEC) begin
                // Zero is derived locally from the result, not from any ALU flag.
                r_result <= bus.alu_out;
                r_zero   <= (bus.alu_out == '0);
            end
        end
    end

    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_op     = r_op;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;
    assign bus.rsp_zero   = r_zero;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    logic busy;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 0;

    alu_arbiter_if #(.DATA_W(32), .OP_W(3)) bus ();

    alu_arbiter #(.DATA_W(32), .OP_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            3'd4:    return ~a;
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU stand-in.
    assign bus.alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = computing, 2 = response pending.
    int          m_phase = 0;
    bit          m_last  = 1;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic [2:0]  m_op = 0;
    bit          m_id = 0, m_zero = 0;

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_phase = 0; m_last = 1; m_a = 0; m_b = 0; m_op = 0;
            m_id = 0; m_res = 0; m_zero = 0;
        end else if (m_phase == 0) begin
            g = -1;
            if (bus.req0_valid && bus.req1_valid) g = m_last ? 0 : 1;
            else if (bus.req0_valid)              g = 0;
            else if (bus.req1_valid)              g = 1;
            if (g == 0) begin
                m_a = bus.req0_a; m_b = bus.req0_b; m_op = bus.req0_op;
            end else if (g == 1) begin
                m_a = bus.req1_a; m_b = bus.req1_b; m_op = bus.req1_op;
            end
            if (g >= 0) begin
                m_id = (g == 1); m_last = (g == 1); m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_res  = alu_ref(m_a, m_b, m_op);
            m_zero = (m_res == 0);
            m_phase = 2;
        end else if (bus.rsp_ready) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        bit e0, e1;
        if (cmp_en) begin
            e0 = (m_phase == 0) && bus.req0_valid && (!bus.req1_valid || m_last);
            e1 = (m_phase == 0) && bus.req1_valid && (!bus.req0_valid || !m_last);
            chk("m_busy",  busy,           m_phase != 0);
            chk("m_rdy0",  bus.req0_ready, e0);
            chk("m_rdy1",  bus.req1_ready, e1);
            chk("m_valid", bus.rsp_valid,  m_phase == 2);
            chk("m_alu_a", bus.alu_a,      m_a);
            chk("m_alu_b", bus.alu_b,      m_b);
            chk("m_alu_op", bus.alu_op,    m_op);
            if (m_phase == 2) begin
                chk("m_id",     bus.rsp_id,     m_id);
                chk("m_result", bus.rsp_result, m_res);
                chk("m_zero",   bus.rsp_zero,   m_zero);
            end
        end
    end

    task automatic set_req(input bit id, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        if (!id) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    // Waits (bounded) for rsp_valid at a negedge; returns negedges elapsed.
    task automatic wait_rsp(input string nm, output int n);
        bit got = 0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) begin
                got = 1;
                break;
            end
        end
        chk({nm, "_rsp_seen"}, got, 1);
    endtask

    task automatic run_op(input string nm, input bit id, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] er, input bit ez);
        bit got = 0;
        int n;
        @(posedge clk); #1;
        set_req(id, 1, a, b, op);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk({nm, "_accept"}, got, 1);
        @(posedge clk); #1;
        set_req(id, 0, 0, 0, 0);
        wait_rsp(nm, n);
        chk({nm, "_latency"}, n, 2);
        chk({nm, "_id"},      bus.rsp_id,     id);
        chk({nm, "_result"},  bus.rsp_result, er);
        chk({nm, "_zero"},    bus.rsp_zero,   ez);
    endtask

    initial begin
        int n;
        rst_n = 0;
        bus.rsp_ready = 1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        // Model pins.
        chk("pin_sub",  alu_ref(32'd5, 32'd3, 3'd1), 32'd2);
        chk("pin_wrap", alu_ref(32'hFFFFFFFF, 32'd1, 3'd0), 32'd0);
        chk("pin_not",  alu_ref(32'd0, 32'd9, 3'd4), 32'hFFFFFFFF);
        chk("pin_ill",  alu_ref(32'd7, 32'd9, 3'd6), 32'd0);

        // Reset held for two edges.
        @(posedge clk); @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_rdy0",  bus.req0_ready, 0);
        chk("rst_rdy1",  bus.req1_ready, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Single op on requester 0.
        run_op("single", 0, 32'd5, 32'd3, 3'd1, 32'd2, 0);

        // Contention from reset: order 0,1,0,1.
        @(posedge clk); #1; rst_n = 0;
        @(posedge clk); #1; rst_n = 1;
        set_req(0, 1, 32'd7, 32'd2, 3'd0);
        set_req(1, 1, 32'hFFFFFFFF, 32'd1, 3'd0);
        for (int i = 0; i < 4; i++) begin
            wait_rsp("rr", n);
            chk("rr_id",     bus.rsp_id,     i % 2);
            chk("rr_result", bus.rsp_result, (i % 2) ? 32'd0 : 32'd9);
            chk("rr_zero",   bus.rsp_zero,   i % 2);
        end
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        // Backpressure: response held for 5 cycles.
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        set_req(1, 1, 32'h10, 32'h20, 3'd2);
        @(posedge clk); #1;
        set_req(1, 0, 0, 0, 0);
        wait_rsp("bp", n);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  bus.rsp_valid, 1);
            chk("bp_busy",   busy, 1);
            chk("bp_result", bus.rsp_result, 32'h30);
            chk("bp_id",     bus.rsp_id, 1);
            chk("bp_rdy0",   bus.req0_ready, 0);
            @(negedge clk);
        end
        chk("bp_hold6", bus.rsp_valid, 1);
        bus.rsp_ready = 1;
        @(negedge clk);
        chk("bp_idle_busy",  busy, 0);
        chk("bp_idle_valid", bus.rsp_valid, 0);

        // Illegal opcode and not-a.
        run_op("ill110", 0, 32'h1234, 32'h55, 3'd6, 32'd0, 1);
        run_op("nota",   1, 32'd0, 32'h77, 3'd4, 32'hFFFFFFFF, 0);

        // Reset while in EXEC abandons the operation.
        @(posedge clk); #1;
        set_req(1, 1, 32'd1, 32'd1, 3'd0);
        @(negedge clk);
        chk("rexec_accept", bus.req1_ready, 1);
        @(posedge clk); #1;
        set_req(1, 0, 0, 0, 0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rexec_novalid", bus.rsp_valid, 0);
        end
        // last_grant back to 1, so contention goes to requester 0.
        @(posedge clk); #1;
        set_req(0, 1, 32'd10, 32'd4, 3'd3);
        set_req(1, 1, 32'd10, 32'd4, 3'd2);
        @(negedge clk);
        chk("rexec_gnt0", bus.req0_ready, 1);
        chk("rexec_gnt1", bus.req1_ready, 0);
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        wait_rsp("rexec", n);
        chk("rexec_result", bus.rsp_result, 32'd0);
        chk("rexec_zero",   bus.rsp_zero, 1);
        run_op("after", 0, 32'hFFFF0000, 32'h0000FFFF, 3'd2, 32'hFFFFFFFF, 0);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            set_req(0, $urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                    3'($urandom_range(0, 7)));
            set_req(1, $urandom_range(0, 1), $urandom, $urandom, 3'($urandom_range(0, 7)));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 63) != 0);
        end
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        bus.rsp_ready = 1;
        rst_n = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
